// File: rtl/serial_subtractor_pkg.sv
// Shared types and reset constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic RST_BUSY = 1'b0;
  localparam logic RST_DONE = 1'b0;
  localparam logic RST_B_O  = 1'b0;
  localparam logic RST_ZERO = 1'b0;
  localparam logic RST_OVF  = 1'b0;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester and the serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_o;
  logic             zero;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, b_o, zero, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, b_o, zero, ovf
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: diff = x - y - b_i with borrow out.
module full_subtractor (
  output logic diff,
  output logic b_o,
  input  logic x,
  input  logic y,
  input  logic b_i
);
  assign diff = x ^ y ^ b_i;
  assign b_o  = (~x & y) | (~(x ^ y) & b_i);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell and a borrow flop.
// Optional signed-overflow flag enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic             load_c, shift_c, last_c, finish_c;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CNT_W-1:0] cnt;
  logic             bor;
  logic             d_c, bor_nxt_c;

  logic             busy_q, done_q, b_o_q, zero_q;
  logic [WIDTH-1:0] diff_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    load_c   = 1'b0;
    shift_c  = 1'b0;
    last_c   = 1'b0;
    finish_c = 1'b0;
    case (state)
      IDLE:    load_c   = bus.start;
      SHIFT:   begin
        shift_c = 1'b1;
        last_c  = (cnt == LAST_CNT);
      end
      DONE:    finish_c = 1'b1;
      default: ;
    endcase
  end

  full_subtractor u_cell (
    .diff (d_c),
    .b_o  (bor_nxt_c),
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .b_i  (bor)
  );

  // Operand/result shift registers, borrow and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bor    <= 1'b0;
      cnt    <= '0;
    end else if (load_c) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      bor    <= 1'b0;
      cnt    <= '0;
    end else if (shift_c) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= {d_c, res_sr[WIDTH-1:1]};
      bor    <= bor_nxt_c;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result registers: only move when the DONE state publishes a result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= RST_BUSY;
      done_q <= RST_DONE;
      diff_q <= '0;
      b_o_q  <= RST_B_O;
      zero_q <= RST_ZERO;
    end else begin
      busy_q <= (state != IDLE);
      done_q <= finish_c;
      if (finish_c) begin
        diff_q <= res_sr;
        b_o_q  <= bor;
        zero_q <= (res_sr == '0);
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf_pend, ovf_q;

  // Operand MSBs sit at bit 0 during the last shift, alongside the result MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pend <= RST_OVF;
      ovf_q    <= RST_OVF;
    end else begin
      if (last_c)   ovf_pend <= (a_sr[0] != b_sr[0]) && (d_c != a_sr[0]);
      if (finish_c) ovf_q    <= ovf_pend;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = RST_OVF;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.b_o  = b_o_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  localparam logic OVF_8001 = 1'b1;
`else
  localparam logic OVF_8001 = 1'b0;
`endif

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the done pulse; lat counts edges after the start edge, -1 on timeout
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    wait_done(lat);
  endtask

  task automatic test_reset();
    n_checks += 6;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff got %h want 00", bus.diff); end
    if (bus.b_o !== 1'b0) begin n_fail++; $display("FAIL reset_b_o got %b want 0", bus.b_o); end
    if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b want 0", bus.zero); end
    if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
  endtask

  task automatic test_basic();
    int lat;
    do_op(8'd100, 8'd37, lat);
    n_checks += 7;
    if (lat != 9) begin n_fail++; $display("FAIL basic_latency got %0d want 9", lat); end
    if (bus.diff !== 8'd63) begin n_fail++; $display("FAIL basic_diff got %0d want 63", bus.diff); end
    if (bus.b_o !== 1'b0) begin n_fail++; $display("FAIL basic_b_o got %b want 0", bus.b_o); end
    if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL basic_zero got %b want 0", bus.zero); end
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_in_done got %b want 1", bus.busy); end
    tick();
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b want 0", bus.busy); end
  endtask

  task automatic test_borrow();
    int lat;
    do_op(8'd5, 8'd9, lat);
    n_checks += 3;
    if (bus.diff !== 8'hFC) begin n_fail++; $display("FAIL borrow_diff got %h want fc", bus.diff); end
    if (bus.b_o !== 1'b1) begin n_fail++; $display("FAIL borrow_b_o got %b want 1", bus.b_o); end
    if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL borrow_zero got %b want 0", bus.zero); end
    tick();
  endtask

  task automatic test_zero();
    int lat;
    do_op(8'h55, 8'h55, lat);
    n_checks += 3;
    if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL zero_diff got %h want 00", bus.diff); end
    if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL zero_flag got %b want 1", bus.zero); end
    if (bus.b_o !== 1'b0) begin n_fail++; $display("FAIL zero_b_o got %b want 0", bus.b_o); end
    tick();
  endtask

  task automatic test_ovf();
    int lat;
    do_op(8'h80, 8'h01, lat);
    n_checks += 3;
    if (bus.diff !== 8'h7F) begin n_fail++; $display("FAIL ovf_diff got %h want 7f", bus.diff); end
    if (bus.b_o !== 1'b0) begin n_fail++; $display("FAIL ovf_b_o got %b want 0", bus.b_o); end
    if (bus.ovf !== OVF_8001) begin n_fail++; $display("FAIL ovf_flag got %b want %b", bus.ovf, OVF_8001); end
    tick();
  endtask

  task automatic test_hold();
    int lat;
    do_op(8'h10, 8'h01, lat);
    tick();
    bus.start = 1'b1;
    bus.a     = 8'h20;
    bus.b     = 8'h30;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    n_checks += 5;
    if (bus.diff !== 8'h0F) begin n_fail++; $display("FAIL hold_diff got %h want 0f", bus.diff); end
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL hold_done got %b want 0", bus.done); end
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy got %b want 1", bus.busy); end
    wait_done(lat);
    if (bus.diff !== 8'hF0) begin n_fail++; $display("FAIL hold_new_diff got %h want f0", bus.diff); end
    if (bus.b_o !== 1'b1) begin n_fail++; $display("FAIL hold_new_b_o got %b want 1", bus.b_o); end
    tick();
  endtask

  // START held for 20 edges; operands change after edge 3
  task automatic test_back_to_back();
    int       done_at[$];
    logic [W-1:0] diff_at[$];
    bus.start = 1'b1;
    bus.a     = 8'd100;
    bus.b     = 8'd37;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 3) begin
        bus.a = 8'd5;
        bus.b = 8'd9;
      end
      if (bus.done === 1'b1) begin
        done_at.push_back(c);
        diff_at.push_back(bus.diff);
      end
    end
    bus.start = 1'b0;
    n_checks += 1;
    if (done_at.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count got %0d want 2", done_at.size());
    end else begin
      n_checks += 4;
      if (done_at[0] != 10) begin n_fail++; $display("FAIL b2b_first_edge got %0d want 10", done_at[0]); end
      if (diff_at[0] !== 8'd63) begin n_fail++; $display("FAIL b2b_first_diff got %h want 3f", diff_at[0]); end
      if (done_at[1] - done_at[0] != 10) begin
        n_fail++; $display("FAIL b2b_spacing got %0d want 10", done_at[1] - done_at[0]);
      end
      if (diff_at[1] !== 8'hFC) begin n_fail++; $display("FAIL b2b_second_diff got %h want fc", diff_at[1]); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.start = 1'b1;
    bus.a     = 8'h30;
    bus.b     = 8'h12;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    n_checks += 9;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b want 0", bus.done); end
    if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL rstmid_diff got %h want 00", bus.diff); end
    if (bus.b_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_b_o got %b want 0", bus.b_o); end
    if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL rstmid_zero got %b want 0", bus.zero); end
    if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf got %b want 0", bus.ovf); end
    if (dut.state !== IDLE) begin n_fail++; $display("FAIL rstmid_state got %0d want 0", dut.state); end
    tick();
    tick();
    rst_n = 1'b1;
    do_op(8'h30, 8'h12, lat);
    if (lat != 9) begin n_fail++; $display("FAIL rstmid_latency got %0d want 9", lat); end
    if (bus.diff !== 8'h1E) begin n_fail++; $display("FAIL rstmid_diff_after got %h want 1e", bus.diff); end
    tick();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_borrow();
    test_zero();
    test_ovf();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
